// File: rtl/fpga_template_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fpga_template_pkg                                            |
// | Description : Shared types and constants for the sample RAM read path.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpga_template_pkg;

    localparam int SAMPLE_W          = 24;
    localparam int DEFAULT_FRAME_LEN = 512;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        PRESENT = 3'd4
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_ram_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : First set bit of a mask, searching upward from a start       |
// |               index with wrap-around. Purely combinational.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    localparam logic [IDX_W:0] C_NUM_REQ = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] w_pos;

    // Walk offsets from farthest to nearest so the bit closest to start wins.
    always_comb begin
        grant = '0;
        index = '0;
        w_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = {1'b0, start} + (IDX_W+1)'(i);
            if (w_pos >= C_NUM_REQ) begin
                w_pos = w_pos - C_NUM_REQ;
            end
            if (mask[w_pos[IDX_W-1:0]]) begin
                grant                    = '0;
                grant[w_pos[IDX_W-1:0]] = 1'b1;
                index                    = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sample_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : sample_ram_arbiter                                           |
// | Description : Reads a completed audio frame out of the sample RAM once per |
// |               subscribed consumer, round-robin. Optional dropped-pulse     |
// |               counter enabled by SAMPLE_RAM_ARB_OVERRUN_CNT_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sample_ram_arbiter
    import fpga_template_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = SAMPLE_W,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int ADDR_W    = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                buffer_ready_i,
    output logic                ram_rd_en_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    input  logic [DATA_W-1:0]   ram_rdata_i,
    input  logic [NUM_REQ-1:0]  sub_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [NUM_REQ-1:0]  rd_valid_o,
    input  logic [NUM_REQ-1:0]  rd_ready_i,
    output logic                rd_last_o,
    output logic                busy_o,
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
    output logic [15:0]         overrun_cnt_o,
`endif
    output logic                overrun_o
);

    localparam int                IDX_W      = idx_width(NUM_REQ);
    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  C_LAST_REQ = IDX_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [NUM_REQ-1:0]   r_pend;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_frame_start;
    logic [ADDR_W-1:0]    r_idx;
    logic [DATA_W-1:0]    r_data;
    logic                 r_overrun;

    logic [NUM_REQ-1:0]   w_pick_grant;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_drop;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .mask    (r_pend),
        .start   (r_rr_ptr),
        .grant   (w_pick_grant),
        .index   (w_pick_idx)
    );

    assign w_last     = (r_idx == C_LAST_IDX);
    assign w_drop     = buffer_ready_i && (r_state != IDLE);
    assign ram_addr_o = r_idx;
    assign rd_data_o  = r_data;
    assign busy_o     = (r_state != IDLE);
    assign overrun_o  = r_overrun;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ram_rd_en_o  = 1'b0;
        rd_valid_o   = '0;
        rd_last_o    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (buffer_ready_i && (|sub_i)) begin
                    w_next_state = SELECT;
                end
            end
            SELECT: begin
                w_next_state = ISSUE;
            end
            ISSUE: begin
                ram_rd_en_o  = 1'b1;
                w_next_state = CAPTURE;
            end
            CAPTURE: begin
                w_next_state = PRESENT;
            end
            PRESENT: begin
                rd_valid_o = r_grant;
                rd_last_o  = w_last;
                w_accept   = |(r_grant & rd_ready_i);
                if (w_accept) begin
                    if (!w_last) begin
                        w_next_state = ISSUE;
                    end else if (|r_pend) begin
                        w_next_state = SELECT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend        <= '0;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_frame_start <= 1'b0;
            r_idx         <= '0;
            r_data        <= '0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (buffer_ready_i) begin
                        r_pend        <= sub_i;
                        r_frame_start <= 1'b1;
                    end
                end
                SELECT: begin
                    r_pend        <= r_pend & ~w_pick_grant;
                    r_grant       <= w_pick_grant;
                    r_idx         <= '0;
                    r_frame_start <= 1'b0;
                    // Only the first grant of a frame moves the rotation point.
                    if (r_frame_start) begin
                        r_rr_ptr <= (w_pick_idx == C_LAST_REQ) ? '0 : w_pick_idx + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_data <= ram_rdata_i;
                end
                PRESENT: begin
                    if (w_accept && !w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
    logic [15:0] r_overrun_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun_cnt <= '0;
        end else if (w_drop && (r_overrun_cnt != 16'hFFFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 16'd1;
        end
    end

    assign overrun_cnt_o = r_overrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sample_ram_arbiter                                        |
// | Description : Self-checking bench for sample_ram_arbiter against a         |
// |               frame-level stream model with round-robin rotation.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sample_ram_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int DATA_W    = 24;
    localparam int FRAME_LEN = 512;
    localparam int ADDR_W    = 10;
    localparam int MAX_CYC   = 20000;

    logic                clk_i          = 1'b0;
    logic                rst_ni         = 1'b0;
    logic                buffer_ready_i = 1'b0;
    logic                ram_rd_en_o;
    logic [ADDR_W-1:0]   ram_addr_o;
    logic [DATA_W-1:0]   ram_rdata_i    = '0;
    logic [NUM_REQ-1:0]  sub_i          = '0;
    logic [DATA_W-1:0]   rd_data_o;
    logic [NUM_REQ-1:0]  rd_valid_o;
    logic [NUM_REQ-1:0]  rd_ready_i     = '0;
    logic                rd_last_o;
    logic                busy_o;
    logic                overrun_o;
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
    logic [15:0]         overrun_cnt_o;
`endif

    sample_ram_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .buffer_ready_i (buffer_ready_i),
        .ram_rd_en_o    (ram_rd_en_o),
        .ram_addr_o     (ram_addr_o),
        .ram_rdata_i    (ram_rdata_i),
        .sub_i          (sub_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .rd_last_o      (rd_last_o),
        .busy_o         (busy_o),
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
        .overrun_cnt_o  (overrun_cnt_o),
`endif
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port RAM model: data one cycle after the strobe.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk_i) begin
        if (ram_rd_en_o) ram_rdata_i <= ram[ram_addr_o];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;

    int                obs_c[$];
    logic [DATA_W-1:0] obs_d[$];
    logic              obs_l[$];
    int                exp_c[$];
    logic [DATA_W-1:0] exp_d[$];
    logic              exp_l[$];

    int                rd_cnt, v0_cnt, stall_viol, multi_viol;
    logic [ADDR_W-1:0] first_addr;
    logic [NUM_REQ-1:0] p_valid, p_ready;
    logic [DATA_W-1:0] p_data;
    logic              p_last;

    // Passive monitor: records every accepted sample and protocol violations.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int c = 0; c < NUM_REQ; c++) begin
                if (rd_valid_o[c] && rd_ready_i[c]) begin
                    obs_c.push_back(c);
                    obs_d.push_back(rd_data_o);
                    obs_l.push_back(rd_last_o);
                end
            end
            if ($countones(rd_valid_o) > 1) multi_viol++;
            if (p_valid != '0 && (p_valid & p_ready) == '0 &&
                (rd_valid_o !== p_valid || rd_data_o !== p_data || rd_last_o !== p_last))
                stall_viol++;
            if (ram_rd_en_o) begin
                rd_cnt++;
                if (rd_cnt == 1) first_addr = ram_addr_o;
            end
            if (rd_valid_o[0]) v0_cnt++;
            p_valid = rd_valid_o;
            p_ready = rd_ready_i;
            p_data  = rd_data_o;
            p_last  = rd_last_o;
        end else begin
            p_valid = '0;
        end
    end

    task automatic clear_obs();
        obs_c.delete(); obs_d.delete(); obs_l.delete();
        rd_cnt = 0; v0_cnt = 0; stall_viol = 0; multi_viol = 0;
        first_addr = '1; p_valid = '0;
    endtask

    // Reference: rotate from model_rr, serve each subscriber the whole frame.
    task automatic build_exp(input logic [NUM_REQ-1:0] sub);
        int  c, nxt;
        bit  first;
        exp_c.delete(); exp_d.delete(); exp_l.delete();
        first = 1'b1;
        nxt   = model_rr;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (model_rr + k) % NUM_REQ;
            if (sub[c]) begin
                if (first) begin
                    nxt   = (c + 1) % NUM_REQ;
                    first = 1'b0;
                end
                for (int i = 0; i < FRAME_LEN; i++) begin
                    exp_c.push_back(c);
                    exp_d.push_back(ram[i]);
                    exp_l.push_back(i == FRAME_LEN - 1);
                end
            end
        end
        model_rr = nxt;
    endtask

    task automatic fill_ram(input bit rnd);
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = rnd ? DATA_W'($urandom) : DATA_W'(i);
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0; buffer_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_rr = 0;
    endtask

    task automatic pulse();
        @(posedge clk_i); #1 buffer_ready_i = 1'b1;
        @(posedge clk_i); #1 buffer_ready_i = 1'b0;
    endtask

    // Cycles run after the pulse edge until busy_o is seen low; optional extra pulse.
    task automatic run_frame(input bit rnd, input int pulse_at,
                             input logic [NUM_REQ-1:0] late_sub, output int cyc);
        cyc = 0;
        while (busy_o && cyc < MAX_CYC) begin
            @(posedge clk_i); #1;
            cyc++;
            buffer_ready_i = (cyc == pulse_at);
            if (cyc == pulse_at) sub_i = late_sub;
            rd_ready_i = rnd ? NUM_REQ'($urandom) : '1;
        end
        buffer_ready_i = 1'b0;
        if (cyc >= MAX_CYC) begin
            n_checks++; n_fail++;
            $display("FAIL frame_timeout: busy_o still %0b after %0d cycles", busy_o, cyc);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (ram_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", ram_rd_en_o); end
        n_checks++; if (ram_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", ram_addr_o); end
        n_checks++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", rd_data_o); end
        n_checks++; if (rd_valid_o !== '0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid_o); end
        n_checks++; if (rd_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", rd_last_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
        n_checks++; if (overrun_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_overrun_cnt: got %0d want 0", overrun_cnt_o); end
`endif
        @(posedge clk_i); #1 rst_ni = 1'b1;
        model_rr = 0;
    endtask

    task automatic test_full_frame();
        int cyc;
        fill_ram(1'b0); clear_obs();
        sub_i = 2'b11; rd_ready_i = '1;
        build_exp(sub_i);
        pulse();
        run_frame(1'b0, -1, '0, cyc);
        // busy_o high from the pulse edge through edge 3073, low after edge 3074.
        n_checks++; if (cyc !== 3074) begin n_fail++; $display("FAIL full_busy_len: got %0d want 3074", cyc); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL full_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL full_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_rotation();
        int cyc;
        clear_obs();
        sub_i = 2'b11; rd_ready_i = '1;
        build_exp(sub_i);
        pulse();
        run_frame(1'b0, -1, '0, cyc);
        n_checks++; if (obs_c.size() == 0 || obs_c[0] !== 1) begin n_fail++; $display("FAIL rot_first: got c%0d want c1", obs_c.size() ? obs_c[0] : -1); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL rot_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL rot_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_single_sub();
        int cyc;
        clear_obs();
        sub_i = 2'b10; rd_ready_i = '1;
        build_exp(sub_i);
        pulse();
        run_frame(1'b0, -1, '0, cyc);
        n_checks++; if (cyc !== 1537) begin n_fail++; $display("FAIL single_busy_len: got %0d want 1537", cyc); end
        n_checks++; if (rd_cnt !== FRAME_LEN) begin n_fail++; $display("FAIL single_rd_en_count: got %0d want %0d", rd_cnt, FRAME_LEN); end
        n_checks++; if (v0_cnt !== 0) begin n_fail++; $display("FAIL single_valid0: got %0d cycles want 0", v0_cnt); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL single_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_random_ready();
        int cyc;
        fill_ram(1'b1); clear_obs();
        sub_i = 2'b11; rd_ready_i = NUM_REQ'($urandom);
        build_exp(sub_i);
        pulse();
        run_frame(1'b1, -1, '0, cyc);
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d violations want 0", stall_viol); end
        n_checks++; if (multi_viol !== 0) begin n_fail++; $display("FAIL rand_onehot: got %0d violations want 0", multi_viol); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL rand_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_overrun();
        int cyc;
        // Pulse mid-frame with a changed subscription: dropped, frame unchanged.
        reset_dut(); fill_ram(1'b0); clear_obs();
        sub_i = 2'b01; rd_ready_i = '1;
        build_exp(sub_i);
        pulse();
        run_frame(1'b0, 100, 2'b11, cyc);
        n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_mid_flag: got %b want 1", overrun_o); end
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
        n_checks++; if (overrun_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovr_mid_cnt: got %0d want 1", overrun_cnt_o); end
`endif
        n_checks++; if (cyc !== 1537) begin n_fail++; $display("FAIL ovr_mid_busy_len: got %0d want 1537", cyc); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL ovr_mid_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL ovr_mid_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
        // Pulse coinciding with the final accept is also dropped.
        reset_dut(); clear_obs();
        sub_i = 2'b01;
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b want 0", overrun_o); end
        pulse();
        run_frame(1'b0, 1536, 2'b01, cyc);
        @(posedge clk_i); #1;
        n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_edge_flag: got %b want 1", overrun_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ovr_edge_no_restart: busy got %b want 0", busy_o); end
`ifdef SAMPLE_RAM_ARB_OVERRUN_CNT_EN
        n_checks++; if (overrun_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovr_edge_cnt: got %0d want 1", overrun_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        fill_ram(1'b0); clear_obs();
        sub_i = 2'b11; rd_ready_i = '1;
        pulse();
        cyc = 0;
        while ((cyc < 40 || rd_valid_o == '0) && cyc < 200) begin
            @(posedge clk_i); #1 cyc++;
        end
        @(negedge clk_i); rst_ni = 1'b0;
        #1;
        n_checks++; if (rd_valid_o !== '0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", rd_valid_o); end
        n_checks++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %0h want 0", rd_data_o); end
        n_checks++; if (ram_addr_o !== '0) begin n_fail++; $display("FAIL mid_rst_addr: got %0h want 0", ram_addr_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
        n_checks++; if (rd_last_o !== 1'b0 || ram_rd_en_o !== 1'b0 || overrun_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_misc: last %b rd_en %b ovr %b want 000", rd_last_o, ram_rd_en_o, overrun_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        model_rr = 0;
        clear_obs();
        build_exp(sub_i);
        pulse();
        run_frame(1'b0, -1, '0, cyc);
        n_checks++; if (first_addr !== '0) begin n_fail++; $display("FAIL mid_rst_first_addr: got %0h want 0", first_addr); end
        n_checks++; if (obs_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL mid_rst_count: got %0d want %0d", obs_c.size(), exp_c.size()); end
        for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
            n_checks++;
            if (obs_c[k] !== exp_c[k] || obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL mid_rst_sample %0d: got c%0d d%0h l%0b want c%0d d%0h l%0b", k, obs_c[k], obs_d[k], obs_l[k], exp_c[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_full_frame();
        test_rotation();
        test_single_sub();
        test_random_ready();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
